// File: rtl/sudoku_dp_if.sv
// sudoku_dp_if: control flags, seeds and board outputs of the 4x4 Sudoku
// datapath. clka and restart stay plain ports on the datapath itself.
//
// Signalling: every *_flag is a single-cycle command qualifier sampled on the
// rising clock edge. There is no valid/ready backpressure: the datapath
// always accepts a flag on the edge where it is high, and all outputs are
// registered and valid from the edge after the command.
interface sudoku_dp_if;
  logic        new_game;
  logic        set_board_flag;
  logic        set_diff_flag;
  logic        row_flag;
  logic        col_flag;
  logic        val_flag;
  logic        check_flag;
  logic [3:0]  rand_setup;
  logic [3:0]  rand_A;
  logic [3:0]  rand_B;
  logic [3:0]  diff_cell_val;

  logic        solved;
  logic [15:0] fill_flag;
  logic        game_state;
  logic [2:0]  user_board_0, user_board_1, user_board_2, user_board_3;
  logic [2:0]  user_board_4, user_board_5, user_board_6, user_board_7;
  logic [2:0]  user_board_8, user_board_9, user_board_10, user_board_11;
  logic [2:0]  user_board_12, user_board_13, user_board_14, user_board_15;
  logic [2:0]  real_board_0, real_board_1, real_board_2, real_board_3;
  logic [2:0]  real_board_4, real_board_5, real_board_6, real_board_7;
  logic [2:0]  real_board_8, real_board_9, real_board_10, real_board_11;
  logic [2:0]  real_board_12, real_board_13, real_board_14, real_board_15;

  // Game FSM side: drives commands, observes boards.
  modport master (
    output new_game, set_board_flag, set_diff_flag, row_flag, col_flag,
           val_flag, check_flag, rand_setup, rand_A, rand_B, diff_cell_val,
    input  solved, fill_flag, game_state,
           user_board_0, user_board_1, user_board_2, user_board_3,
           user_board_4, user_board_5, user_board_6, user_board_7,
           user_board_8, user_board_9, user_board_10, user_board_11,
           user_board_12, user_board_13, user_board_14, user_board_15,
           real_board_0, real_board_1, real_board_2, real_board_3,
           real_board_4, real_board_5, real_board_6, real_board_7,
           real_board_8, real_board_9, real_board_10, real_board_11,
           real_board_12, real_board_13, real_board_14, real_board_15
  );

  // Datapath side.
  modport slave (
    input  new_game, set_board_flag, set_diff_flag, row_flag, col_flag,
           val_flag, check_flag, rand_setup, rand_A, rand_B, diff_cell_val,
    output solved, fill_flag, game_state,
           user_board_0, user_board_1, user_board_2, user_board_3,
           user_board_4, user_board_5, user_board_6, user_board_7,
           user_board_8, user_board_9, user_board_10, user_board_11,
           user_board_12, user_board_13, user_board_14, user_board_15,
           real_board_0, real_board_1, real_board_2, real_board_3,
           real_board_4, real_board_5, real_board_6, real_board_7,
           real_board_8, real_board_9, real_board_10, real_board_11,
           real_board_12, real_board_13, real_board_14, real_board_15
  );
endinterface

// File: rtl/sudoku_dp.sv
// sudoku_dp: 4x4 Sudoku datapath. Generates a solved board from a seed,
// derives a difficulty-dependent hint mask, accepts row/col/value entries
// into the player board and flags when the player board equals the solution.
// Optional feature: define SUDOKU_DP_ERASE_EN to let val_flag with
// diff_cell_val[2]=1 latch an empty value, so a following check clears the
// cell; hint cells stay protected.
module sudoku_dp (
  input logic         clka,
  input logic         restart,
  sudoku_dp_if.slave  bus
);

  typedef logic [15:0][2:0] board_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        game_active;
  logic        entry_en;

  board_t      real_q, real_d;
  board_t      user_q, user_d;
  logic [15:0] fill_q, fill_d;
  logic [1:0]  prow_q, prow_d;
  logic [1:0]  pcol_q, pcol_d;
  logic [2:0]  pval_q, pval_d;
  logic        solved_q, solved_d;
  logic [2:0]  val_new;
  logic [3:0]  cell_idx;
  logic [15:0] mask;

  // Latin-square solution: base row pattern, band/row swap, then digit shift.
  function automatic board_t gen_board(input logic [3:0] seed);
    board_t     brd;
    logic [1:0] rp;
    logic [1:0] cc;
    logic [1:0] b;
    brd = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rp = r[1:0] ^ seed[3:2];
        cc = c[1:0];
        b  = {rp[0], 1'b0} + {1'b0, rp[1]} + cc;
        b  = b + seed[1:0];
        brd[4*r+c] = {1'b0, b} + 3'd1;
      end
    end
    return brd;
  endfunction

  // Hint pattern for the difficulty, rotated left and optionally reversed.
  function automatic logic [15:0] build_mask(input logic [1:0] d,
                                             input logic [3:0] rot,
                                             input logic       rev);
    logic [15:0] p;
    logic [31:0] dbl;
    logic [15:0] m;
    logic [15:0] o;
    case (d)
      2'd0:    p = 16'hB7ED;
      2'd1:    p = 16'hA5A5;
      default: p = 16'h8421;
    endcase
    dbl = {p, p} << rot;
    m   = dbl[31:16];
    o   = m;
    if (rev) begin
      for (int i = 0; i < 16; i++) o[i] = m[15-i];
    end
    return o;
  endfunction

  // Game state register: idle until a hint mask is loaded.
  always_ff @(posedge clka) begin
    if (restart) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: new_game ends the game, set_diff_flag starts one; a
  // simultaneous set_board_flag outranks set_diff_flag.
  always_comb begin
    state_d = state_q;
    if (bus.new_game)            state_d = ST_IDLE;
    else if (bus.set_board_flag) state_d = state_q;
    else if (bus.set_diff_flag)  state_d = ST_ACTIVE;
  end

  // FSM outputs: entries apply only in an active game with no higher-priority
  // command on the same edge.
  always_comb begin
    game_active = (state_q == ST_ACTIVE);
    entry_en    = !bus.new_game && !bus.set_board_flag && !bus.set_diff_flag;
  end

  // Value that val_flag would latch this cycle; also the check bypass value.
  always_comb begin
    val_new = {1'b0, bus.diff_cell_val[1:0]} + 3'd1;
`ifdef SUDOKU_DP_ERASE_EN
    if (bus.diff_cell_val[2]) val_new = 3'd0;
`endif
  end

  assign cell_idx = {prow_q, pcol_q};
  assign mask     = build_mask(bus.diff_cell_val[1:0], bus.rand_A, bus.rand_B[0]);

  // Datapath next state with priority new_game > set_board > set_diff > entry.
  always_comb begin
    real_d = real_q;
    user_d = user_q;
    fill_d = fill_q;
    prow_d = prow_q;
    pcol_d = pcol_q;
    pval_d = pval_q;
    if (bus.new_game) begin
      user_d = '0;
      fill_d = '0;
      prow_d = '0;
      pcol_d = '0;
      pval_d = '0;
    end else if (bus.set_board_flag) begin
      real_d = gen_board(bus.rand_setup);
    end else if (bus.set_diff_flag) begin
      fill_d = mask;
      for (int i = 0; i < 16; i++) user_d[i] = mask[i] ? real_q[i] : 3'd0;
    end else if (entry_en) begin
      if (bus.row_flag) prow_d = bus.diff_cell_val[1:0];
      if (bus.col_flag) pcol_d = bus.diff_cell_val[1:0];
      if (bus.val_flag) pval_d = val_new;
      if (bus.check_flag && game_active && !fill_q[cell_idx])
        user_d[cell_idx] = bus.val_flag ? val_new : pval_q;
    end
    solved_d = (state_d == ST_ACTIVE) && (user_d == real_d);
  end

  // Datapath registers.
  always_ff @(posedge clka) begin
    if (restart) begin
      real_q   <= '0;
      user_q   <= '0;
      fill_q   <= '0;
      prow_q   <= '0;
      pcol_q   <= '0;
      pval_q   <= '0;
      solved_q <= 1'b0;
    end else begin
      real_q   <= real_d;
      user_q   <= user_d;
      fill_q   <= fill_d;
      prow_q   <= prow_d;
      pcol_q   <= pcol_d;
      pval_q   <= pval_d;
      solved_q <= solved_d;
    end
  end

  // Upper field bits are reserved in the default build.
  logic unused_bits;
  assign unused_bits = ^{bus.diff_cell_val[3:2], bus.rand_B[3:1]};

  assign bus.solved     = solved_q;
  assign bus.fill_flag  = fill_q;
  assign bus.game_state = state_q;

  assign bus.user_board_0  = user_q[0];
  assign bus.user_board_1  = user_q[1];
  assign bus.user_board_2  = user_q[2];
  assign bus.user_board_3  = user_q[3];
  assign bus.user_board_4  = user_q[4];
  assign bus.user_board_5  = user_q[5];
  assign bus.user_board_6  = user_q[6];
  assign bus.user_board_7  = user_q[7];
  assign bus.user_board_8  = user_q[8];
  assign bus.user_board_9  = user_q[9];
  assign bus.user_board_10 = user_q[10];
  assign bus.user_board_11 = user_q[11];
  assign bus.user_board_12 = user_q[12];
  assign bus.user_board_13 = user_q[13];
  assign bus.user_board_14 = user_q[14];
  assign bus.user_board_15 = user_q[15];

  assign bus.real_board_0  = real_q[0];
  assign bus.real_board_1  = real_q[1];
  assign bus.real_board_2  = real_q[2];
  assign bus.real_board_3  = real_q[3];
  assign bus.real_board_4  = real_q[4];
  assign bus.real_board_5  = real_q[5];
  assign bus.real_board_6  = real_q[6];
  assign bus.real_board_7  = real_q[7];
  assign bus.real_board_8  = real_q[8];
  assign bus.real_board_9  = real_q[9];
  assign bus.real_board_10 = real_q[10];
  assign bus.real_board_11 = real_q[11];
  assign bus.real_board_12 = real_q[12];
  assign bus.real_board_13 = real_q[13];
  assign bus.real_board_14 = real_q[14];
  assign bus.real_board_15 = real_q[15];

endmodule

// File: tb/tb_sudoku_dp.sv
// tb_sudoku_dp: bench for sudoku_dp. A behavioural game model predicts the
// registered outputs for every cycle; predictions go into exp_q when the
// inputs are driven and are popped and compared after the clock edge.
module tb_sudoku_dp;

  localparam int W = 113; // {solved, fill[15:0], user[47:0], real[47:0]}

  logic clka;
  logic restart;
  sudoku_dp_if bus ();

  sudoku_dp dut (
    .clka    (clka),
    .restart (restart),
    .bus     (bus)
  );

  // clock
  initial clka = 1'b0;
  always #5 clka = ~clka;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model state
  logic [2:0]  m_real[16];
  logic [2:0]  m_user[16];
  logic [15:0] m_fill;
  logic        m_active;
  logic [1:0]  m_prow, m_pcol;
  logic [2:0]  m_pval;
  logic        m_solved;
  int          base0[4][4] = '{'{1,2,3,4}, '{3,4,1,2}, '{2,3,4,1}, '{4,1,2,3}};

  logic [47:0] dut_user, dut_real;
  assign dut_user = {bus.user_board_15, bus.user_board_14, bus.user_board_13, bus.user_board_12,
                     bus.user_board_11, bus.user_board_10, bus.user_board_9,  bus.user_board_8,
                     bus.user_board_7,  bus.user_board_6,  bus.user_board_5,  bus.user_board_4,
                     bus.user_board_3,  bus.user_board_2,  bus.user_board_1,  bus.user_board_0};
  assign dut_real = {bus.real_board_15, bus.real_board_14, bus.real_board_13, bus.real_board_12,
                     bus.real_board_11, bus.real_board_10, bus.real_board_9,  bus.real_board_8,
                     bus.real_board_7,  bus.real_board_6,  bus.real_board_5,  bus.real_board_4,
                     bus.real_board_3,  bus.real_board_2,  bus.real_board_1,  bus.real_board_0};

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_flags();
    restart            = 1'b0;
    bus.new_game       = 1'b0;
    bus.set_board_flag = 1'b0;
    bus.set_diff_flag  = 1'b0;
    bus.row_flag       = 1'b0;
    bus.col_flag       = 1'b0;
    bus.val_flag       = 1'b0;
    bus.check_flag     = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_apply();
    logic [2:0]  nv;
    logic [15:0] p, rot;
    int          rp, k, idx;
    logic        match;
    if (restart) begin
      for (int i = 0; i < 16; i++) begin m_real[i] = 0; m_user[i] = 0; end
      m_fill = 0; m_active = 0; m_prow = 0; m_pcol = 0; m_pval = 0; m_solved = 0;
      return;
    end
    nv = 3'(bus.diff_cell_val[1:0]) + 3'd1;
`ifdef SUDOKU_DP_ERASE_EN
    if (bus.diff_cell_val[2]) nv = 3'd0;
`endif
    if (bus.new_game) begin
      for (int i = 0; i < 16; i++) m_user[i] = 0;
      m_fill = 0; m_active = 0; m_prow = 0; m_pcol = 0; m_pval = 0;
    end else if (bus.set_board_flag) begin
      k = int'(bus.rand_setup[1:0]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          rp = r ^ int'(bus.rand_setup[3:2]);
          m_real[4*r+c] = 3'(((base0[rp][c] - 1 + k) % 4) + 1);
        end
    end else if (bus.set_diff_flag) begin
      case (bus.diff_cell_val[1:0])
        2'd0:    p = 16'hB7ED;
        2'd1:    p = 16'hA5A5;
        default: p = 16'h8421;
      endcase
      for (int i = 0; i < 16; i++) rot[(i + int'(bus.rand_A)) % 16] = p[i];
      for (int i = 0; i < 16; i++) m_fill[i] = bus.rand_B[0] ? rot[15-i] : rot[i];
      for (int i = 0; i < 16; i++) m_user[i] = m_fill[i] ? m_real[i] : 3'd0;
      m_active = 1'b1;
    end else begin
      idx = 4 * int'(m_prow) + int'(m_pcol);
      if (bus.check_flag && m_active && !m_fill[idx])
        m_user[idx] = bus.val_flag ? nv : m_pval;
      if (bus.row_flag) m_prow = bus.diff_cell_val[1:0];
      if (bus.col_flag) m_pcol = bus.diff_cell_val[1:0];
      if (bus.val_flag) m_pval = nv;
    end
    match = 1'b1;
    for (int i = 0; i < 16; i++) if (m_user[i] != m_real[i]) match = 1'b0;
    m_solved = m_active && match;
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [47:0] u, r;
    for (int i = 0; i < 16; i++) begin u[3*i +: 3] = m_user[i]; r[3*i +: 3] = m_real[i]; end
    return {m_solved, m_fill, u, r};
  endfunction

  task automatic compare_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 48'd1, 48'd0);
      return;
    end
    e = exp_q.pop_front();
    check("solved", 48'(bus.solved), 48'(e[112]));
    check("fill",   48'(bus.fill_flag), 48'(e[111:96]));
    check("user",   dut_user, e[95:48]);
    check("real",   dut_real, e[47:0]);
  endtask

  // One cycle: predict, push, clock, compare, release flags.
  task automatic step();
    model_apply();
    exp_q.push_back(pack_model());
    @(posedge clka);
    @(negedge clka);
    compare_out();
    clear_flags();
  endtask

  task automatic enter(input int r, input int c, input int v);
    bus.row_flag = 1'b1; bus.diff_cell_val = 4'(r); step();
    bus.col_flag = 1'b1; bus.diff_cell_val = 4'(c); step();
    bus.val_flag = 1'b1; bus.check_flag = 1'b1; bus.diff_cell_val = 4'(v - 1); step();
  endtask

  logic [47:0] seed0_board;

  initial begin
    clear_flags();
    bus.rand_setup = 0; bus.rand_A = 0; bus.rand_B = 0; bus.diff_cell_val = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) seed0_board[3*(4*r+c) +: 3] = 3'(base0[r][c]);

    // reset
    @(negedge clka);
    restart = 1'b1; step();
    check("rst_solved", 48'(bus.solved), 48'd0);
    check("rst_user", dut_user, 48'd0);

    // check before any game is ignored
    bus.check_flag = 1'b1; bus.val_flag = 1'b1; bus.diff_cell_val = 4'd2; step();

    // board generation, seed 0
    bus.set_board_flag = 1'b1; bus.rand_setup = 4'h0; step();
    check("real_seed0", dut_real, seed0_board);

    // mask, difficulty 0
    bus.set_diff_flag = 1'b1; bus.diff_cell_val = 4'd0; bus.rand_A = 0; bus.rand_B = 0; step();
    check("fill_d0", 48'(bus.fill_flag), 48'h00B7ED);

    // hint lock and overwrite
    enter(0, 0, 4);
    check("hint_lock", 48'(bus.user_board_0), 48'd1);
    enter(0, 1, 3);
    check("ovr_first", 48'(bus.user_board_1), 48'd3);
    enter(0, 1, 2);
    check("ovr_second", 48'(bus.user_board_1), 48'd2);
    enter(1, 0, 3);
    enter(2, 3, 1);
    check("not_solved", 48'(bus.solved), 48'd0);
    enter(3, 2, 2);
    check("solved_rise", 48'(bus.solved), 48'd1);

    // new game keeps the solution
    bus.new_game = 1'b1; step();
    check("ng_solved", 48'(bus.solved), 48'd0);
    check("ng_real", dut_real, seed0_board);

    // board generation, seed A
    bus.set_board_flag = 1'b1; bus.rand_setup = 4'hA; step();
    check("real0_seedA", 48'(bus.real_board_0), 48'd4);

    // random command mix
    for (int n = 0; n < 150; n++) begin
      bus.new_game       = ($urandom_range(0, 24) == 0);
      bus.set_board_flag = ($urandom_range(0, 9) == 0);
      bus.set_diff_flag  = ($urandom_range(0, 7) == 0);
      bus.row_flag       = ($urandom_range(0, 2) == 0);
      bus.col_flag       = ($urandom_range(0, 2) == 0);
      bus.val_flag       = ($urandom_range(0, 2) == 0);
      bus.check_flag     = ($urandom_range(0, 1) == 0);
      bus.rand_setup     = 4'($urandom_range(0, 15));
      bus.rand_A         = 4'($urandom_range(0, 15));
      bus.rand_B         = 4'($urandom_range(0, 15));
      bus.diff_cell_val  = 4'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
